seq_shift_add_mult: RTL and testbench
=====================================

# seq_shift_add_mult

Sequential shift-add signed multiplier for the 8x8 signed-multiplier datapath. It directly feeds the 15-bit partial-product register stage. It converts two 8-bit two's-complement operands to sign/magnitude, then accumulates the 15-bit magnitude product one multiplier bit per cycle. It strobes each partial sum out with an enable pulse, and on completion presents the final signed 16-bit product with a done pulse.

## Interface
- No parameters; widths fixed: operands 8 bits, magnitude/partial product 15 bits, product 16 bits.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- start  input  1  request; sampled only in IDLE.
- a  input  8  multiplicand, signed two's complement.
- b  input  8  multiplier, signed two's complement.
- pp_out  output  15  running partial-product magnitude (accumulator); drives the partial-product register data input.
- pp_en  output  1  high for one cycle after each accumulation step; drives the partial-product register enable.
- product  output  16  final signed product, two's complement; held until the next completion.
- sign  output  1  sign of the last completed product.
- busy  output  1  high from the cycle after start acceptance through DONE.
- done  output  1  one-cycle pulse when product/sign are updated.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - On an edge with start=1, capture mcand = |a| zero-extended to 15 bits, mplr = |b| (8 bits), cnt = 0, acc = 0.
  - Capture sgn = a[7]^b[7]. Go to RUN.
- Magnitude rule: |x| = x[7] ? (~x+1) : x, computed at 8-bit width. |−128| = 128 (0x80), treated as unsigned.
- RUN, each edge:
  - If mplr[0]=1, acc += mcand; otherwise acc unchanged.
  - Then mcand <<= 1, mplr >>= 1, cnt += 1, pp_en <= 1.
  - After the 8th step (cnt reaches 8), go to DONE.
- No early termination: RUN always lasts exactly 8 cycles, even when mplr becomes 0.
- DONE, on the edge entering it:
  - sign <= (acc_final != 0) ? sgn : 0.
  - product <= sign ? −{1'b0,acc} : {1'b0,acc} (16-bit).
  - done <= 1. Next edge: done <= 0, go to IDLE.
- Max magnitude is 128*128 = 16384 = 0x4000. It fits in 15 bits, so the accumulator never overflows and carry out of bit 14 is impossible.
- start is ignored in RUN and DONE. It is not queued.
- pp_out = acc at all times (registered). pp_en = 0 outside the cycles that follow RUN updates.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, acc/pp_out=0, pp_en=0, product=0, sign=0, busy=0, done=0, cnt=0, mcand=0, mplr=0.
- Reset release takes effect at the next clock edge. Reset mid-RUN or mid-DONE aborts the operation; no done pulse occurs.
- Edge E0: start sampled in IDLE. busy=1 from E0.
- Edges E1..E8: RUN steps. After Ek, pp_out holds the sum of the first k bits and pp_en=1 for that cycle. pp_en is high continuously for 8 cycles.
- Edge E8 also updates product/sign and asserts done (E8–E9). pp_en is high in the same cycle (final step).
- Edge E9: done=0, busy=0, IDLE. The earliest next start is sampled at E9.
- Throughput: one multiply per 9 cycles. Start-to-done latency: 8 cycles.

## Test plan
- Reset: hold rst=0 with random inputs and start=1. Required: all outputs 0 and busy stays 0. Release rst; outputs remain 0 until a start is accepted.
- a=3, b=5, start pulse. Required:
  - pp_out after E1..E8 = 3,3,15,15,15,15,15,15, with pp_en high for those 8 cycles.
  - At E8: product=0x000F, sign=0, one-cycle done.
- a=−128 (0x80), b=−128. Required: pp_out final 0x4000, product=0x4000, sign=0.
- a=−7 (0xF9), b=6. Required: final pp_out=42 (0x002A), product=0xFFD6, sign=1.
- a=0, b=−5 (0xFB). Required: pp_out stays 0, product=0, sign=0 (no negative zero).
- Start at E4 of a running op with different operands. Required: it is ignored, and the result matches the first operands. Separately, assert rst=0 at E5: outputs clear immediately, done never pulses, and the next start completes normally.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult
// Sequential shift-add signed multiplier (8x8 -> 16). The operands are converted
// to sign/magnitude and the 15-bit magnitude product is accumulated one multiplier
// bit per cycle over exactly 8 cycles. Each partial sum is strobed out with pp_en.
// On completion the signed product is presented with a one-cycle done pulse.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (0 = reset)
//   start    request, sampled only while idle
//   a, b     signed 8-bit multiplicand / multiplier
//   pp_out   running 15-bit magnitude accumulator (registered)
//   pp_en    high for the cycle following each accumulation step
//   product  signed 16-bit result, held until the next completion
//   sign     sign of the last completed product
//   busy     high while an operation is in progress (RUN and DONE)
//   done     one-cycle pulse when product/sign are updated
module seq_shift_add_mult (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic        [14:0] pp_out,
    output logic               pp_en,
    output logic signed [15:0] product,
    output logic               sign,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [14:0] mcand;
    logic [7:0]  mplr;
    logic [3:0]  cnt;
    logic        sgn;
    logic [14:0] acc_nxt;
    logic        last_step;
    logic        sign_nxt;

    // Magnitude at 8-bit width; -128 yields 0x80, read as unsigned 128.
    function automatic logic [7:0] mag8(input logic [7:0] x);
        return x[7] ? 8'(~x + 8'd1) : x;
    endfunction

    // Re-apply the sign to the magnitude product.
    function automatic logic signed [15:0] apply_sign(input logic neg, input logic [14:0] m);
        logic signed [15:0] ext;
        ext = $signed({1'b0, m});
        return neg ? -ext : ext;
    endfunction

    assign acc_nxt   = mplr[0] ? (pp_out + mcand) : pp_out;
    assign last_step = (cnt == 4'd7);
    // A zero product is always reported positive.
    assign sign_nxt  = (acc_nxt != 15'd0) ? sgn : 1'b0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            pp_out  <= '0;
            pp_en   <= 1'b0;
            product <= '0;
            sign    <= 1'b0;
            done    <= 1'b0;
        end else begin
            pp_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {7'd0, mag8(a)};
                        mplr   <= mag8(b);
                        cnt    <= '0;
                        pp_out <= '0;
                        sgn    <= a[7] ^ b[7];
                    end
                end
                RUN: begin
                    // One multiplier bit per cycle; never terminates early.
                    pp_out <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplr   <= mplr >> 1;
                    cnt    <= cnt + 4'd1;
                    pp_en  <= 1'b1;
                    if (last_step) begin
                        sign    <= sign_nxt;
                        product <= apply_sign(sign_nxt, acc_nxt);
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

    logic               clk;
    logic               rst;
    logic               start;
    logic        [7:0]  a;
    logic        [7:0]  b;
    logic        [14:0] pp_out;
    logic               pp_en;
    logic        [15:0] product;
    logic               sign;
    logic               busy;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;

    seq_shift_add_mult dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .pp_out  (pp_out),
        .pp_en   (pp_en),
        .product (product),
        .sign    (sign),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic        sgn;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Partial sum after k steps: |a| times the low k bits of |b|.
    function automatic int exp_pp(input int sa, input int sb, input int k);
        int ma;
        int mb;
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        return ma * (mb % (1 << k));
    endfunction

    // Called at a negedge; runs one full multiply and checks every cycle.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] prod_exp, input logic sgn_exp,
                         input string tag);
        int sa;
        int sb;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        chk({tag, "/e0_busy"}, int'(busy), 1);
        chk({tag, "/e0_pp_en"}, int'(pp_en), 0);
        chk({tag, "/e0_pp_out"}, int'(pp_out), 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("%s/pp_out_e%0d", tag, k), int'(pp_out), exp_pp(sa, sb, k));
            chk($sformatf("%s/pp_en_e%0d", tag, k), int'(pp_en), 1);
            chk($sformatf("%s/done_e%0d", tag, k), int'(done), (k == 8) ? 1 : 0);
        end
        chk({tag, "/product"}, int'(product), int'(prod_exp));
        chk({tag, "/sign"}, int'(sign), int'(sgn_exp));
        @(negedge clk);
        chk({tag, "/e9_done"}, int'(done), 0);
        chk({tag, "/e9_busy"}, int'(busy), 0);
        chk({tag, "/e9_pp_en"}, int'(pp_en), 0);
        chk({tag, "/e9_product_held"}, int'(product), int'(prod_exp));
    endtask

    initial begin
        int sa;
        int sb;
        int p;

        vecs[0] = '{8'h03, 8'h05, 16'h000F, 1'b0};
        vecs[1] = '{8'h80, 8'h80, 16'h4000, 1'b0};
        vecs[2] = '{8'hF9, 8'h06, 16'hFFD6, 1'b1};
        vecs[3] = '{8'h00, 8'hFB, 16'h0000, 1'b0};
        vecs[4] = '{8'h7F, 8'h80, 16'hC080, 1'b1};
        vecs[5] = '{8'h80, 8'h7F, 16'hC080, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 16'hFF80, 1'b1};

        // Reset held with activity on the inputs
        rst = 1'b0;
        start = 1'b1;
        a = 8'h00;
        b = 8'h00;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            chk($sformatf("rst%0d/busy", i), int'(busy), 0);
            chk($sformatf("rst%0d/pp_out", i), int'(pp_out), 0);
            chk($sformatf("rst%0d/pp_en", i), int'(pp_en), 0);
            chk($sformatf("rst%0d/done", i), int'(done), 0);
            chk($sformatf("rst%0d/product", i), int'(product), 0);
            chk($sformatf("rst%0d/sign", i), int'(sign), 0);
        end
        start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d/busy", i), int'(busy), 0);
            chk($sformatf("post_rst%0d/pp_out", i), int'(pp_out), 0);
            chk($sformatf("post_rst%0d/product", i), int'(product), 0);
        end

        // 3 x 5 partial sums written out explicitly
        begin
            int seq35[8] = '{3, 3, 15, 15, 15, 15, 15, 15};
            a = 8'd3;
            b = 8'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk($sformatf("seq35/pp_out_e%0d", k + 1), int'(pp_out), seq35[k]);
            end
            chk("seq35/product", int'(product), 16'h000F);
            chk("seq35/done", int'(done), 1);
            @(negedge clk);
        end

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].sgn, $sformatf("vec%0d", i));
        end

        // Start during RUN is ignored
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                a = 8'h55;
                b = 8'h66;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk($sformatf("ign/pp_out_e%0d", k), int'(pp_out), exp_pp(3, 5, k));
        end
        chk("ign/product", int'(product), 16'h000F);
        chk("ign/done", int'(done), 1);
        @(negedge clk);
        chk("ign/e9_busy", int'(busy), 0);
        @(negedge clk);
        chk("ign/not_queued", int'(busy), 0);

        // Reset asserted mid-RUN aborts the operation
        a = 8'hF9;
        b = 8'h06;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("abort/pp_out_e%0d", k), int'(pp_out), exp_pp(-7, 6, k));
        end
        rst = 1'b0;
        #1;
        chk("abort/pp_out", int'(pp_out), 0);
        chk("abort/pp_en", int'(pp_en), 0);
        chk("abort/busy", int'(busy), 0);
        chk("abort/product", int'(product), 0);
        chk("abort/sign", int'(sign), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort/done_c%0d", i), int'(done), 0);
        end
        rst = 1'b1;
        do_op(8'hF9, 8'h06, 16'hFFD6, 1'b1, "after_abort");

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 0) ra = 8'h80;
            if (i == 1) rb = 8'h00;
            sa = int'($signed(ra));
            sb = int'($signed(rb));
            p = sa * sb;
            do_op(ra, rb, 16'(p), (p < 0), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
